// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte buffer behind the UART receiver, FWFT valid/ready output
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop, drop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                      (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign m_valid  = ~empty;
    assign m_data   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign overflow = overflow_q;

    assign pop  = m_valid & m_ready;
    assign push = rx_done & (~full | pop);
    assign drop = rx_done & full & ~pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q[ADDR_WIDTH-1:0]] = rx_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_done = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          ovf_clr = 1'b0;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_done(rx_done),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    int            mdl_cnt = 0;
    logic          mdl_ovf = 1'b0;

    // Monitor: every accepted output byte must be the oldest expected one.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_byte: got %02h, expected no output", m_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    n_bad++;
                    $display("FAIL out_byte: got %02h, expected %02h", m_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},    32'(count),    32'(mdl_cnt));
        chk({tag, ".full"},     32'(full),     32'(mdl_cnt == DEPTH));
        chk({tag, ".empty"},    32'(empty),    32'(mdl_cnt == 0));
        chk({tag, ".m_valid"},  32'(m_valid),  32'(mdl_cnt != 0));
        chk({tag, ".overflow"}, 32'(overflow), 32'(mdl_ovf));
    endtask

    task automatic step(input logic d, input logic [DW-1:0] data, input logic rdy,
                        input logic clr, input string tag);
        logic p_pop, p_push, p_drop;
        rx_done = d;
        rx_data = data;
        m_ready = rdy;
        ovf_clr = clr;
        p_pop  = (mdl_cnt > 0) && rdy;
        p_push = d && ((mdl_cnt < DEPTH) || p_pop);
        p_drop = d && (mdl_cnt == DEPTH) && !p_pop;
        if (p_push) exp_q.push_back(data);
        @(posedge clk);
        #1;
        mdl_cnt = mdl_cnt + int'(p_push) - int'(p_pop);
        mdl_ovf = p_drop | (mdl_ovf & ~clr);
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_state("in_reset");
        chk("in_reset.m_data", 32'(m_data), 32'h00);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_state("idle");
        chk("idle.m_data", 32'(m_data), 32'h00);

        step(1'b1, 8'h41, 1'b0, 1'b0, "single_push");
        chk("single.m_data", 32'(m_data), 32'h41);
        step(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        chk("fill.head", 32'(m_data), 32'h00);

        step(1'b1, 8'hAA, 1'b0, 1'b0, "drop");
        step(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");
        step(1'b1, 8'hAA, 1'b0, 1'b1, "drop_and_clr");
        step(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr2");

        step(1'b1, 8'h55, 1'b1, 1'b0, "full_push_pop");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        step(1'b0, 8'h00, 1'b1, 1'b0, "drained");

        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'h80 + 8'(i), (mdl_cnt >= 3) || (i % 4 == 3), 1'b0, "wrap");
            chk("wrap.occupancy_le5", 32'(count <= 5), 32'd1);
        end
        while (mdl_cnt > 3) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
        chk("wrap.left", 32'(exp_q.size()), 32'd3);

        rx_done = 1'b0;
        m_ready = 1'b0;
        rstn    = 1'b0;
        #1;
        exp_q.delete();
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        check_state("mid_reset");
        chk("mid_reset.m_data", 32'(m_data), 32'h00);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_state("after_reset");

        step(1'b1, 8'h77, 1'b0, 1'b0, "post_push");
        chk("post.m_data", 32'(m_data), 32'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_pop");
        chk("final.scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
